byte_sub: RTL and testbench
===========================

# byte_sub

AES-128 SubBytes stage. The block applies the FIPS-197 forward S-box independently to each of the 16 bytes of a 128-bit state word and returns the result through a registered output. It sits in the round datapath between AddRoundKey and ShiftRows, and can be reused for the key-expansion SubWord step by using 4 of its byte lanes.

## Interface
- Parameters: none.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies `data` on the current cycle.
- data  input  128  state word; byte lane i = data[8i+7:8i], i = 0..15.
- sb  output  128  substituted state; lane i = SBOX(data lane i).
- out_valid  output  1  qualifies `sb`.

## Operation
- Each lane uses the fixed 256-entry forward AES S-box, for example SBOX(00)=63, SBOX(01)=7C, SBOX(53)=ED, SBOX(FF)=16.
- Lanes are fully independent. There is no mixing across bytes and no key input.
- The byte ordering of `data` is preserved in `sb`: the MSB byte in gives the MSB byte out.
- The block has no flow control and no backpressure. It accepts a new word every cycle.
- `sb` and `out_valid` are captured every cycle.
  - When in_valid=0, out_valid falls to 0 and `sb` still updates with SBOX(data).
  - Consumers must ignore `sb` while out_valid=0.

## Timing
- Default latency is 1 cycle: the word presented at edge N appears on `sb` with out_valid=1 after edge N+1, i.e. during cycle N+1.
- Throughput is 1 word per cycle.
- Reset values: sb = 128'h0, out_valid = 0. Any internal pipeline registers also reset to 0.
- Asserting rst mid-stream clears all stages immediately, without waiting for a clock edge. Words in flight are discarded.
- On the first edge after rst deasserts, normal capture resumes.
- The S-box lookup is purely combinational between registers. It has no state machine.

## Configuration
- BYTE_SUB_PIPE_EN: when defined, an input register stage (data plus in_valid) is inserted before the S-box lookup.
  - Latency becomes 2 cycles.
  - Throughput stays 1 word per cycle.
  - Both stages reset to 0.
- When BYTE_SUB_PIPE_EN is undefined, there is only the output register and latency is 1 cycle.
- Port list and functional results are identical in both builds.

## Structure
- The shared package aes_pkg holds:
  - the 256-entry S-box constant array;
  - the state-width constant (128) and the byte-lane count (16);
  - a function sbox(byte) -> byte.
- One sub-module is natural: aes_sbox, an 8-bit combinational lookup. It is instantiated 16 times through a generate loop over the lanes.
- The top level contains only the lane generate loop and the pipeline/output registers.

## Test plan
- Reset: hold rst=1, apply data=all ones -> sb=0 and out_valid=0 throughout. Release rst, apply data=0 with in_valid=1 -> next cycle sb=6363...63 (16 bytes) and out_valid=1.
- FIPS-197 vector: data=193de3bea0f4e22b9ac68d2ae9f84808, in_valid=1 -> after the configured latency, sb=d42711aee0bf98f1b8b45de51e415230.
- All-ones: data=ffff...ff -> sb=1616...16.
- Lane independence: data=000102...0f -> sb=637c777bf26b6fc53001672bfed7ab76.
- Exhaustive check: sweep every byte value 00..FF through every lane at one word per cycle. Compare against the reference table, and check that out_valid tracks in_valid delayed by the configured latency.
- Asynchronous reset: assert rst between clock edges while a valid word is in flight -> sb and out_valid go to 0 at once, with no spurious valid after release.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: state geometry and the FIPS-197 forward S-box.
// Used by aes_sbox and byte_sub (optional input stage: BYTE_SUB_PIPE_EN).
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int LANES   = 16;

    // Forward S-box, indexed by the input byte (row = high nibble).
    localparam logic [7:0] SBOX_TABLE [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] value);
        return SBOX_TABLE[value];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte combinational forward S-box lookup; one instance per state lane.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);

    assign sub_val = sbox(byte_val);

endmodule

// File: rtl/byte_sub.sv
// AES SubBytes: 16 independent S-box lanes feeding a registered output.
// Defining BYTE_SUB_PIPE_EN adds an input register stage (latency 2 instead of 1).
module byte_sub
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [STATE_W-1:0] data,
    output logic [STATE_W-1:0] sb,
    output logic               out_valid
);

    logic [STATE_W-1:0] lookup_data;
    logic [STATE_W-1:0] lookup_sb;
    logic               lookup_valid;

`ifdef BYTE_SUB_PIPE_EN
    logic [STATE_W-1:0] data_q;
    logic               valid_q;

    // Input stage registers the raw word so the lookup gets a full cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data;
            valid_q <= in_valid;
        end
    end

    assign lookup_data  = data_q;
    assign lookup_valid = valid_q;
`else
    assign lookup_data  = data;
    assign lookup_valid = in_valid;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox u_sbox (
            .byte_val (lookup_data[8*i +: 8]),
            .sub_val  (lookup_sb[8*i +: 8])
        );
    end

    // The output captures every cycle; sb is meaningful only while out_valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb        <= '0;
            out_valid <= 1'b0;
        end else begin
            sb        <= lookup_sb;
            out_valid <= lookup_valid;
        end
    end

endmodule

// File: tb/tb_byte_sub.sv
// Self-checking bench for byte_sub; the reference S-box is derived from GF(2^8) arithmetic.
// Latency expectation follows BYTE_SUB_PIPE_EN.
module tb_byte_sub;

`ifdef BYTE_SUB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [127:0] data = '0;
    logic [127:0] sb;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0]   refTable [256];
    logic [128:0] pipeQ [$];
    logic [127:0] expSb;
    logic         expValid;

    typedef struct {
        string        name;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [4];

    byte_sub dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data      (data),
        .sb        (sb),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        if (a == 8'h00) return 8'h00;
        for (int k = 0; k < 254; k++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] w = {a, a};
        return w[15-n -: 8];
    endfunction

    function automatic logic [7:0] refSbox(input logic [7:0] a);
        logic [7:0] b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] refWord(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = refTable[d[8*i +: 8]];
        return r;
    endfunction

    task automatic resetModel();
        pipeQ.delete();
        for (int k = 0; k < LAT - 1; k++) pipeQ.push_back(129'd0);
        expSb    = '0;
        expValid = 1'b0;
    endtask

    task automatic applyStimulus(input logic v, input logic [127:0] d);
        logic [128:0] head;
        in_valid = v;
        data     = d;
        @(posedge clk);
        #1;
        pipeQ.push_back({v, d});
        head     = pipeQ.pop_front();
        expValid = head[128];
        expSb    = refWord(head[127:0]);
    endtask

    task automatic checkOutput(input string name);
        checks++;
        if (sb !== expSb) begin
            errors++;
            $display("[TB] FAIL %s sb: got %h expected %h", name, sb, expSb);
        end
        checks++;
        if (out_valid !== expValid) begin
            errors++;
            $display("[TB] FAIL %s out_valid: got %b expected %b", name, out_valid, expValid);
        end
    endtask

    task automatic checkIdle(input string name);
        checks++;
        if (sb !== 128'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s: got sb=%h out_valid=%b expected sb=0 out_valid=0", name, sb, out_valid);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] w;
        logic         v;

        for (int k = 0; k < 256; k++) refTable[k] = refSbox(8'(k));

        vecs[0].name = "zeros";
        vecs[0].data = 128'h0;
        vecs[0].exp  = {16{8'h63}};
        vecs[1].name = "fips197";
        vecs[1].data = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        vecs[1].exp  = 128'hd42711aee0bf98f1b8b45de51e415230;
        vecs[2].name = "all_ones";
        vecs[2].data = {16{8'hff}};
        vecs[2].exp  = {16{8'h16}};
        vecs[3].name = "lane_index";
        vecs[3].data = 128'h000102030405060708090a0b0c0d0e0f;
        vecs[3].exp  = 128'h637c777bf26b6fc53001672bfed7ab76;

        // Reset held with valid all-ones input must keep the outputs cleared.
        rst      = 1'b1;
        in_valid = 1'b1;
        data     = {16{8'hff}};
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkIdle("reset_hold");
        end
        rst = 1'b0;
        resetModel();

        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b1, vecs[n].data);
            checkOutput(vecs[n].name);
            for (int k = 0; k < LAT - 1; k++) begin
                applyStimulus(1'b0, vecs[n].data);
                checkOutput(vecs[n].name);
            end
            checks++;
            if (sb !== vecs[n].exp || out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL vec_%s: got sb=%h valid=%b expected sb=%h valid=1",
                         vecs[n].name, sb, out_valid, vecs[n].exp);
            end
        end

        // Every byte value through every lane, with valid toggling randomly.
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(k + 16 * i);
            v = 1'($urandom_range(0, 3) != 0);
            applyStimulus(v, w);
            checkOutput("sweep");
        end

        for (int k = 0; k < 200; k++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(1'($urandom_range(0, 1)), w);
            checkOutput("random");
        end

        // Asynchronous reset between edges with a valid word in flight.
        applyStimulus(1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        checkOutput("pre_async");
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkIdle("async_reset_immediate");
        @(posedge clk);
        #1;
        checkIdle("async_reset_edge");
        rst = 1'b0;
        resetModel();
        for (int k = 0; k < LAT + 2; k++) begin
            applyStimulus(1'b0, 128'h0);
            checkOutput("post_reset_drain");
        end
        applyStimulus(1'b1, 128'h000102030405060708090a0b0c0d0e0f);
        checkOutput("post_reset_resume");
        for (int k = 0; k < LAT; k++) begin
            applyStimulus(1'b0, 128'h0);
            checkOutput("post_reset_resume");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
